second_down: RTL and testbench

SECOND_DOWN -- requirements
Module: second_down

---
 rtl/second_down_pkg.sv | 43 ++++
 rtl/second_down_if.sv | 21 ++
 rtl/second_down_counter_down.sv | 35 +++
 rtl/second_down.sv | 84 ++++++++
 tb/tb_second_down.sv | 212 +++++++++++++++++++++
 5 files changed

// File: rtl/second_down_pkg.sv
// Shared types and constants for the seconds down-counter stage.
package second_down_pkg;

  localparam int MODULO_DEF = 60;
  localparam int BITS_DEF   = 6;

  typedef enum logic [1:0] {
    ST_SET  = 2'd0,
    ST_HOLD = 2'd1,
    ST_RUN  = 2'd2
  } state_e;

  // Active-low segments, bit 0 = a ... bit 6 = g.
  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // Digits above 9 cannot occur for legal moduli; show blank if they do.
  function automatic logic [6:0] seg_enc(input logic [3:0] d);
    case (d)
      4'd0:    return SEG_0;
      4'd1:    return SEG_1;
      4'd2:    return SEG_2;
      4'd3:    return SEG_3;
      4'd4:    return SEG_4;
      4'd5:    return SEG_5;
      4'd6:    return SEG_6;
      4'd7:    return SEG_7;
      4'd8:    return SEG_8;
      4'd9:    return SEG_9;
      default: return SEG_BLANK;
    endcase
  endfunction

endpackage

// File: rtl/second_down_if.sv
// Control/status bundle of the seconds stage.
interface second_down_if;
  logic        tick;
  logic        set;
  logic        up;
  logic        run;
  logic        borrow_in;
  logic        sec_borrow;
  logic        sec_zero;
  logic [13:0] sec_7seg;

  modport master (
    output tick, set, up, run, borrow_in,
    input  sec_borrow, sec_zero, sec_7seg
  );

  modport slave (
    input  tick, set, up, run, borrow_in,
    output sec_borrow, sec_zero, sec_7seg
  );
endinterface

// File: rtl/second_down_counter_down.sv
// Modulo-MODULO counter: decrement wraps 0 -> MODULO-1 with a registered
// borrow pulse, increment wraps MODULO-1 -> 0 silently. dec_en wins if both.
module counter_down #(
  parameter int MODULO = 60,
  parameter int BITS   = 6
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            dec_en,
  input  logic            inc_en,
  output logic [BITS-1:0] count,
  output logic            borrow
);
  localparam logic [BITS-1:0] MAX = BITS'(MODULO - 1);

  // Count register and one-cycle borrow flag raised on the wrapping edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count  <= '0;
      borrow <= 1'b0;
    end else begin
      borrow <= 1'b0;
      if (dec_en) begin
        if (count == '0) begin
          count  <= MAX;
          borrow <= 1'b1;
        end else begin
          count <= count - BITS'(1);
        end
      end else if (inc_en) begin
        count <= (count == MAX) ? '0 : count + BITS'(1);
      end
    end
  end
endmodule

// File: rtl/second_down.sv
// Seconds stage of a down-counting timer: button conditioning, mode FSM,
// modulo counter and two-digit 7-segment encoding.
module second_down
  import second_down_pkg::*;
#(
  parameter int MODULO = MODULO_DEF,
  parameter int BITS   = BITS_DEF
) (
  input  logic         clock,
  input  logic         reset,
  second_down_if.slave io
);
  logic            up_s1, up_s2, up_q, up_pulse;
  state_e          state_q, state_d;
  logic            dec_en, inc_en;
  logic [BITS-1:0] count;
  logic            unused_borrow_in;

  // Higher stage's zero request is reserved; nothing here acts on it yet.
  assign unused_borrow_in = io.borrow_in;

  // Two-flop synchronizer plus history flop for the active-low button.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      up_s1 <= 1'b1;
      up_s2 <= 1'b1;
      up_q  <= 1'b1;
    end else begin
      up_s1 <= io.up;
      up_s2 <= up_s1;
      up_q  <= up_s2;
    end
  end

  assign up_pulse = up_q & ~up_s2;

  // Mode state register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state_q <= ST_HOLD;
    else        state_q <= state_d;
  end

  // Next mode and per-mode counter enables; only one enable per state.
  always_comb begin
    state_d = state_q;
    dec_en  = 1'b0;
    inc_en  = 1'b0;
    if (io.set) begin
      state_d = ST_SET;
    end else begin
      case (state_q)
        ST_SET:  state_d = io.run ? ST_RUN : ST_HOLD;
        ST_HOLD: state_d = io.run ? ST_RUN : ST_HOLD;
        ST_RUN:  state_d = io.run ? ST_RUN : ST_HOLD;
        default: state_d = ST_HOLD;
      endcase
    end
    case (state_q)
      ST_SET:  inc_en = up_pulse;
      ST_RUN:  dec_en = io.tick;
      default: ;
    endcase
  end

  counter_down #(.MODULO(MODULO), .BITS(BITS)) u_cnt (
    .clk    (clock),
    .rst_n  (reset),
    .dec_en (dec_en),
    .inc_en (inc_en),
    .count  (count),
    .borrow (io.sec_borrow)
  );

  // Display path is purely combinational from the count register.
  always_comb begin
    int tens_i;
    int ones_i;
    tens_i      = int'(count) / 10;
    ones_i      = int'(count) % 10;
    io.sec_7seg = {seg_enc(4'(tens_i)), seg_enc(4'(ones_i))};
  end

  assign io.sec_zero = (count == '0);
endmodule

// File: tb/tb_second_down.sv
// Scoreboard bench for second_down: a small mode/count model pushes the
// expected display/borrow per action; outputs are popped and compared.
module tb_second_down;
  localparam int MOD    = 60;
  localparam int S_SET  = 0;
  localparam int S_HOLD = 1;
  localparam int S_RUN  = 2;

  typedef struct {
    string tag;
    int    cnt;
    bit    brw;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  second_down_if sif();

  second_down #(.MODULO(MOD), .BITS(6)) dut (
    .clock (clk),
    .reset (rst_n),
    .io    (sif.slave)
  );

  int   n_run = 0;
  int   n_fail = 0;
  int   m_cnt = 0;
  int   m_st = S_HOLD;
  bit   m_brw = 1'b0;
  int   bpulse = 0;
  exp_t sb[$];

  always @(negedge clk) if (sif.sec_borrow === 1'b1) bpulse++;

  function automatic logic [6:0] dig(input int d);
    case (d)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      7: return 7'b1111000;
      8: return 7'b0000000;
      9: return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  function automatic logic [13:0] tb_seg(input int v);
    return {dig(v / 10), dig(v % 10)};
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic push(input string tag);
    exp_t e;
    e.tag = tag;
    e.cnt = m_cnt;
    e.brw = m_brw;
    sb.push_back(e);
  endtask

  task automatic pop_chk();
    exp_t e;
    chk("sb_depth", sb.size(), 1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk({e.tag, ".seg"},  sif.sec_7seg,  tb_seg(e.cnt));
      chk({e.tag, ".zero"}, sif.sec_zero,  (e.cnt == 0));
      chk({e.tag, ".brw"},  sif.sec_borrow, e.brw);
    end
  endtask

  task automatic set_mode(input bit s, input bit r);
    sif.set = s;
    sif.run = r;
    @(negedge clk);
    m_st = s ? S_SET : (r ? S_RUN : S_HOLD);
  endtask

  task automatic tick_once(input string tag);
    sif.tick = 1'b1;
    m_brw = 1'b0;
    if (m_st == S_RUN) begin
      if (m_cnt == 0) begin
        m_cnt = MOD - 1;
        m_brw = 1'b1;
      end else begin
        m_cnt--;
      end
    end
    push(tag);
    @(negedge clk);
    sif.tick = 1'b0;
    pop_chk();
  endtask

  task automatic press(input string tag);
    sif.up = 1'b0;
    m_brw = 1'b0;
    if (m_st == S_SET) m_cnt = (m_cnt + 1) % MOD;
    push(tag);
    repeat (4) @(negedge clk);
    sif.up = 1'b1;
    repeat (2) @(negedge clk);
    pop_chk();
  endtask

  initial begin
    int b0;
    sif.tick = 1'b0;
    sif.set = 1'b0;
    sif.up = 1'b1;
    sif.run = 1'b0;
    sif.borrow_in = 1'b0;
    repeat (3) @(negedge clk);
    push("in_reset");
    pop_chk();
    rst_n = 1'b1;
    @(negedge clk);
    push("released");
    pop_chk();

    // Set to 05, tick ignored in SET, then count down through the wrap.
    set_mode(1'b1, 1'b0);
    for (int i = 0; i < 5; i++) press("set_up");
    tick_once("set_tick");
    set_mode(1'b0, 1'b1);
    b0 = bpulse;
    for (int i = 0; i < 6; i++) tick_once("run_tick");
    m_brw = 1'b0;
    @(negedge clk);
    push("brw_drop");
    pop_chk();
    chk("brw_pulses", bpulse - b0, 1);

    // Reserved borrow_in while nonzero has no effect.
    sif.borrow_in = 1'b1;
    @(negedge clk);
    sif.borrow_in = 1'b0;
    @(negedge clk);
    push("borrow_in");
    pop_chk();

    // HOLD: ticks and presses ignored.
    set_mode(1'b0, 1'b0);
    b0 = bpulse;
    for (int i = 0; i < 10; i++) tick_once("hold_tick");
    for (int i = 0; i < 3; i++) press("hold_up");
    chk("hold_brw", bpulse - b0, 0);

    // SET at 59: increment wraps to 0 without borrow.
    set_mode(1'b1, 1'b0);
    b0 = bpulse;
    press("wrap_up");
    chk("wrap_up_brw", bpulse - b0, 0);
    press("to_one");

    // RUN at 1: tick coincides with up_pulse; only the decrement applies.
    set_mode(1'b0, 1'b1);
    sif.up = 1'b0;
    @(negedge clk);
    @(negedge clk);
    sif.tick = 1'b1;
    m_cnt = 0;
    m_brw = 1'b0;
    push("coincide");
    @(negedge clk);
    sif.tick = 1'b0;
    pop_chk();
    sif.up = 1'b1;
    repeat (3) @(negedge clk);
    push("coincide_after");
    pop_chk();

    // Reset lands two cycles into a press during SET.
    set_mode(1'b1, 1'b0);
    press("pre_reset");
    sif.up = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    m_cnt = 0;
    m_st = S_HOLD;
    m_brw = 1'b0;
    sif.set = 1'b0;
    #1;
    push("async_rst");
    pop_chk();
    sif.up = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    b0 = bpulse;
    repeat (5) @(negedge clk);
    push("post_rst");
    pop_chk();
    chk("post_rst_brw", bpulse - b0, 0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
